zeck_decode: RTL and testbench

//  Iterative Zeckendorf decoder: converts a K-bit Zeckendorf code word into its binary value.

---
 rtl/zeck_decode_pkg.sv | 15 +
 rtl/zeck_decode_fib_gen.sv | 28 ++
 rtl/zeck_decode.sv | 100 ++++++++++
 tb/tb_zeck_decode.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/zeck_decode_pkg.sv
// Shared definitions for the Zeckendorf decoder: FSM state encoding and default sizes.
// The same encoding is used by the other Fibonacci sequence blocks.
package zeck_decode_pkg;

    localparam int unsigned W_DEFAULT = 10;
    localparam int unsigned K_DEFAULT = 15;

    typedef enum logic [1:0] {
        S_Wait = 2'd0,
        S_Init = 2'd1,
        S_Acc  = 2'd2,
        S_Done = 2'd3
    } state_t;

endpackage

// File: rtl/zeck_decode_fib_gen.sv
// Consecutive Fibonacci pair register: load seeds (1,2), step advances to the next pair.
// Width is a parameter so the encode side can reuse it.
module zeck_decode_fib_gen #(
    parameter int unsigned IW = 12
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          load,
    input  logic          step,
    output logic [IW-1:0] t1,
    output logic [IW-1:0] t2
);

    // NOTE: sequential state uses non-blocking assignments so t2 reads the old t1.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            t1 <= '0;
            t2 <= '0;
        end else if (load) begin
            t1 <= IW'(1);
            t2 <= IW'(2);
        end else if (step) begin
            t1 <= t2;
            t2 <= t1 + t2;
        end
    end

endmodule

// File: rtl/zeck_decode.sv
// Iterative Zeckendorf decoder: one code bit per cycle, weights F(i+2) from a Fibonacci pair.
// Flags adjacent set bits (invalid code) and sums that do not fit in W bits.
module zeck_decode
    import zeck_decode_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT,
    parameter int unsigned K = K_DEFAULT
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [K-1:0] Code,
    output logic [W-1:0] Result,
    output logic         Done,
    output logic         Busy,
    output logic         Err,
    output logic         Ovf
);

    localparam int unsigned IW = W + 2;

    state_t          state, state_nx;
    logic [K-1:0]    shreg, shreg_nx;
    logic [IW-1:0]   sum, sum_nx;
    logic            errf, errf_nx;
    logic            finish;
    logic [IW-1:0]   fib_t1;
    logic [IW-1:0]   fib_t2_unused;

    zeck_decode_fib_gen #(.IW(IW)) u_fib (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (state == S_Init),
        .step (state == S_Acc),
        .t1   (fib_t1),
        .t2   (fib_t2_unused)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        sum_nx   = sum;
        errf_nx  = errf;
        case (state)
            S_Wait: begin
                if (Start) begin
                    state_nx = S_Init;
                    shreg_nx = Code;
                end
            end
            S_Init: begin
                sum_nx   = '0;
                errf_nx  = 1'b0;
                state_nx = S_Acc;
            end
            S_Acc: begin
                if (shreg[0])
                    sum_nx = sum + fib_t1;
                if (shreg[0] && shreg[1])
                    errf_nx = 1'b1;
                shreg_nx = shreg >> 1;
                if (shreg_nx == '0)
                    state_nx = S_Done;
            end
            S_Done:  state_nx = S_Wait;
            default: state_nx = S_Wait;
        endcase
    end

    // Outputs are loaded on the edge entering S_Done so Done is high during S_Done itself.
    assign finish = (state == S_Acc) && (state_nx == S_Done);
    assign Busy   = (state != S_Wait);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= S_Wait;
            Result <= '0;
            Done   <= 1'b0;
            Err    <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            Done  <= finish;
            if (finish) begin
                Result <= sum_nx[W-1:0];
                Ovf    <= |sum_nx[IW-1:W];
                Err    <= errf_nx;
            end
        end
    end

    // NOTE: datapath registers need no reset; S_Wait/S_Init initialise them before use.
    always_ff @(posedge Clk) begin
        shreg <= shreg_nx;
        sum   <= sum_nx;
        errf  <= errf_nx;
    end

endmodule

// File: tb/tb_zeck_decode.sv
// Scoreboard bench for zeck_decode: stimulus pushes model results, a monitor pops on Done.
// The model sums Fibonacci weights directly from the code word.
module tb_zeck_decode;

    localparam int W = 10;
    localparam int K = 15;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [K-1:0] Code;
    logic [W-1:0] Result;
    logic         Done;
    logic         Busy;
    logic         Err;
    logic         Ovf;

    zeck_decode #(.W(W), .K(K)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Code   (Code),
        .Result (Result),
        .Done   (Done),
        .Busy   (Busy),
        .Err    (Err),
        .Ovf    (Ovf)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [K-1:0] code;
        logic [W-1:0] res;
        logic         err;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Weight of code bit i is F(i+2), with F(1)=F(2)=1.
    function automatic int weight(input int i);
        int a = 1;
        int b = 1;
        int t;
        for (int j = 0; j < i; j++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic exp_t model(input logic [K-1:0] c, input int accept_cyc);
        exp_t e;
        int   s  = 0;
        int   hi = -1;
        for (int i = 0; i < K; i++)
            if (c[i]) begin
                s  += weight(i);
                hi  = i;
            end
        e.code     = c;
        e.res      = W'(s % (1 << W));
        e.ovf      = (s >= (1 << W));
        e.err      = ((c & (c >> 1)) != '0);
        e.done_cyc = accept_cyc + 2 + ((hi < 0) ? 1 : hi + 1);
        return e;
    endfunction

    function automatic logic [K-1:0] rand_code();
        logic [K-1:0] c;
        c = K'($urandom);
        case ($urandom_range(0, 3))
            0: ;
            1: for (int i = 1; i < K; i++) if (c[i-1]) c[i] = 1'b0;
            2: c = K'($urandom_range(0, 31));
            default: c[K-1] = 1'b1;
        endcase
        return c;
    endfunction

    // Called right after a falling edge; the next rising edge samples Start.
    task automatic drive(input logic s, input logic [K-1:0] c);
        Start = s;
        Code  = c;
        if (s && !Busy)
            sb.push_back(model(c, cyc));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("idle_timeout", {31'b0, Busy}, 0);
    endtask

    task automatic issue(input logic [K-1:0] c);
        @(negedge Clk);
        wait_idle();
        drive(1'b1, c);
        @(negedge Clk);
        drive(1'b0, rand_code());
        wait_idle();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_result"}, 32'(Result), 0);
        check({tag, "_done"}, {31'b0, Done}, 0);
        check({tag, "_busy"}, {31'b0, Busy}, 0);
        check({tag, "_err"}, {31'b0, Err}, 0);
        check({tag, "_ovf"}, {31'b0, Ovf}, 0);
    endtask

    always @(negedge Clk) begin
        if (Rst === 1'b0 && Done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(Result), 32'(mon_e.res));
                check("err", {31'b0, Err}, {31'b0, mon_e.err});
                check("ovf", {31'b0, Ovf}, {31'b0, mon_e.ovf});
                check("done_cycle", cyc, mon_e.done_cyc);
                check("busy_at_done", {31'b0, Busy}, 1);
            end
        end
    end

    initial begin
        int n;
        Rst   = 1'b1;
        Start = 1'b0;
        Code  = '0;
        repeat (3) @(negedge Clk);
        check_cleared("reset");
        Rst = 1'b0;

        issue(15'h0000);
        issue(15'h0214);
        issue(15'h4082);
        issue(15'h5000);
        issue(15'h0003);
        issue(15'h0005);

        // Abort in the fifth accumulate cycle of 0x4082; nothing is queued so any Done fails.
        @(negedge Clk);
        Start = 1'b1;
        Code  = 15'h4082;
        @(negedge Clk);
        Start = 1'b0;
        Code  = rand_code();
        repeat (5) @(negedge Clk);
        check("abort_busy_before", {31'b0, Busy}, 1);
        Rst = 1'b1;
        @(negedge Clk);
        check_cleared("abort");
        Rst = 1'b0;
        repeat (20) @(negedge Clk);
        issue(15'h0214);

        // Random Start pulses, many landing while busy.
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            drive($urandom_range(0, 2) == 0, rand_code());
        end
        @(negedge Clk);
        drive(1'b0, '0);
        wait_idle();

        // Start held high: back-to-back operations.
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            drive(1'b1, rand_code());
        end
        @(negedge Clk);
        drive(1'b0, '0);

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (5) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
